// File: rtl/onehot_sequencer.sv
// onehot_sequencer: a one-hot position counter. It advances up or down through the window
// 0..last_i, can be loaded with an arbitrary position, and flags the wrap point.
//
// Parameters
//   width_p    number of one-hot positions (2..64)
//   init_pos_p position made hot by reset (0..width_p-1)
//
// Ports
//   clk_i      clock; all state updates on the rising edge
//   reset_i    synchronous active-high reset
//   en_i       advance one position this cycle
//   dir_i      0 = up (toward MSB), 1 = down (toward LSB)
//   last_i     terminal position of the active window, clamped to width_p-1
//   load_i     force the hot position to load_idx_i next cycle
//   load_idx_i position to load, clamped to width_p-1
//   count_o    registered one-hot state
//   idx_o      registered binary index of the hot bit (constant 0 unless enabled)
//   term_o     hot bit sits at the wrap point for the current dir_i
//   wrap_o     a rollover takes place at the coming edge
//
// Configuration
//   ONEHOT_SEQUENCER_BINIDX_EN  when defined, idx_o is a real index register;
//                               otherwise idx_o is tied to 0.

module onehot_sequencer #(
  parameter int unsigned width_p    = 8,
  parameter int unsigned init_pos_p = 0,
  localparam int unsigned idx_w     = $clog2(width_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               dir_i,
  input  logic [idx_w-1:0]   last_i,
  input  logic               load_i,
  input  logic [idx_w-1:0]   load_idx_i,
  output logic [width_p-1:0] count_o,
  output logic [idx_w-1:0]   idx_o,
  output logic               term_o,
  output logic               wrap_o
);

  localparam logic [idx_w-1:0]   MaxPos     = idx_w'(width_p - 1);
  localparam logic [idx_w-1:0]   InitPos    = idx_w'(init_pos_p);
  localparam logic [idx_w-1:0]   OnePos     = idx_w'(1);
  localparam logic [width_p-1:0] InitOneHot = width_p'(1) << init_pos_p;

  logic [width_p-1:0] count_q, count_d;
  logic [idx_w-1:0]   pos;
  logic [idx_w-1:0]   eff_last;
  logic [idx_w-1:0]   eff_load;
  logic [idx_w-1:0]   next_pos;
  logic               term;

  // Encode the one-hot state; OR-ing indices is exact because only one bit is set.
  always_comb begin
    pos = '0;
    for (int i = 0; i < int'(width_p); i++) begin
      if (count_q[i]) begin
        pos = pos | idx_w'(i);
      end
    end
  end

  // last_i / load_idx_i can exceed the top position when width_p is not a power of two.
  assign eff_last = (last_i > MaxPos) ? MaxPos : last_i;
  assign eff_load = (load_idx_i > MaxPos) ? MaxPos : load_idx_i;

  assign term   = dir_i ? (pos == '0) : (pos == eff_last);
  assign term_o = term;
  assign wrap_o = en_i & term & ~load_i & ~reset_i;

  always_comb begin
    next_pos = pos;
    if (load_i) begin
      next_pos = eff_load;
    end else if (en_i) begin
      if (pos > eff_last) begin
        // Window shrank beneath the hot bit: restart at 0 (term is 0 here, so no wrap).
        next_pos = '0;
      end else if (!dir_i) begin
        next_pos = term ? '0 : pos + OnePos;
      end else begin
        next_pos = term ? eff_last : pos - OnePos;
      end
    end
    count_d           = '0;
    count_d[next_pos] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= InitOneHot;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

`ifdef ONEHOT_SEQUENCER_BINIDX_EN
  logic [idx_w-1:0] idx_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q <= InitPos;
    end else begin
      idx_q <= next_pos;
    end
  end

  assign idx_o = idx_q;
`else
  assign idx_o = '0;
`endif

endmodule

// File: doc/onehot_sequencer.md
ONEHOT_SEQUENCER -- requirements
Module: onehot_sequencer

Interface
REQ-001 SHALL have parameter width_p, default 8, number of one-hot positions; legal range 2..64.
REQ-002 SHALL have parameter init_pos_p, default 0, position made hot by reset; legal range 0..width_p-1.
REQ-003 SHALL define idx_w as $clog2(width_p) bits for all position-index ports.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 en_i  input  1  advance one position this cycle.
REQ-007 dir_i  input  1  0 = up (shift toward MSB), 1 = down (shift toward LSB).
REQ-008 last_i  input  idx_w  terminal position; active window is positions 0..last_i.
REQ-009 load_i  input  1  force the hot position to load_idx_i next cycle.
REQ-010 load_idx_i  input  idx_w  position to load.
REQ-011 count_o  output  width_p  registered one-hot state.
REQ-012 idx_o  output  idx_w  binary index of the hot bit; present only per REQ-030.
REQ-013 term_o  output  1  combinational; hot bit sits at the wrap point for the current dir_i.
REQ-014 wrap_o  output  1  combinational; a rollover takes place at the coming edge.

Function
REQ-015 SHALL define eff_last as min(last_i, width_p-1), and eff_load as min(load_idx_i, width_p-1).
REQ-016 SHALL keep count_o exactly one-hot in every cycle after the first reset.
REQ-017 Update priority SHALL be reset_i, then load_i, then en_i, then hold.
REQ-018 On load_i=1 (no reset), the next count_o SHALL be the one-hot of eff_load, ignoring en_i and dir_i.
REQ-019 Up advance, with pos < eff_last: SHALL move to pos+1.
REQ-020 Up advance, with pos == eff_last: SHALL move to position 0.
REQ-021 Down advance, with 0 < pos <= eff_last: SHALL move to pos-1.
REQ-022 Down advance, with pos == 0: SHALL move to eff_last.
REQ-023 Advance with pos > eff_last (last_i lowered mid-run) SHALL move to position 0 in either direction, without asserting wrap_o.
REQ-024 term_o SHALL be 1 when (dir_i=0 and pos==eff_last) or (dir_i=1 and pos==0).
REQ-025 wrap_o SHALL equal en_i & term_o & ~load_i & ~reset_i.
REQ-026 eff_last = 0 SHALL hold position 0 on every advance, with term_o=1 and wrap_o=en_i.
REQ-027 dir_i and last_i SHALL take effect in the same cycle they change, with no pipeline latency.

Reset
REQ-028 reset_i=1 at an edge SHALL set count_o to the one-hot of init_pos_p, overriding load_i and en_i; wrap_o SHALL be 0 while reset_i=1.
REQ-029 Reset asserted mid-sequence SHALL discard the current position; the first advance after reset proceeds from init_pos_p.

Configuration
REQ-030 Macro ONEHOT_SEQUENCER_BINIDX_EN, when defined, SHALL compile in idx_o as a registered binary index that updates on the same edge as count_o and always equals the index of its hot bit (reset value init_pos_p).
REQ-031 When ONEHOT_SEQUENCER_BINIDX_EN is undefined, idx_o SHALL be driven constant 0 and no index register SHALL exist; all other behaviour is unchanged.

Verification
REQ-032 width_p=8, last_i=7, dir_i=0, en_i=1 for 9 cycles after reset -> count_o 0x01,0x02,...,0x80,0x01; wrap_o=1 only in the cycle count_o=0x80.
REQ-033 last_i=4, dir_i=1, start at 0x01, en_i=1 -> 0x10,0x08,0x04,0x02,0x01,0x10; wrap_o=1 in each cycle count_o=0x01.
REQ-034 count_o=0x40, last_i lowered to 3, en_i=1 -> next count_o=0x01 with wrap_o=0, then normal 0..3 cycling.
REQ-035 load_i=1, load_idx_i=5, en_i=1, count_o=0x80 -> next count_o=0x20 with wrap_o=0; load_idx_i=7 with width_p=6 -> 0x20.
REQ-036 reset_i=1 together with load_i=1 and en_i=1, init_pos_p=2 -> count_o=0x04; with ONEHOT_SEQUENCER_BINIDX_EN defined, idx_o=2 and tracks count_o on a 20-cycle random en/dir/load run.
